eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 Parameter: MIN_PAYLOAD, 60, minimum bytes before FCS (dest MAC..pad); legal range 0..1514.
REQ-002 Parameter: PREAMBLE_LEN, 7, count of 0x55 bytes before SFD; legal range 1..15.
REQ-003 Parameter: IFG_CYCLES, 12, idle cycles after each frame; legal range 1..255.
REQ-004 clk  input  1  single clock, TX domain; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mac_data_i  input  8  frame byte from TX mux (dest MAC first, no preamble, no FCS).
REQ-007 mac_valid_i  input  1  byte valid; held high for the whole frame, low between frames.
REQ-008 mac_ack_o  output  1  byte on mac_data_i consumed this cycle.
REQ-009 txd_o  output  8  GMII-style transmit byte.
REQ-010 tx_en_o  output  1  txd_o valid.
REQ-011 busy_o  output  1  high in every state except IDLE.
REQ-012 frame_done_o  output  1  one-cycle pulse on the cycle the last frame byte leaves txd_o.

Function
REQ-013 States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
REQ-014 txd_o and tx_en_o are registered; tx_en_o=0 forces txd_o=0x00.
REQ-015 IDLE: mac_valid_i=1 at cycle T -> PREAMBLE; txd_o=0x55 at T+1..T+PREAMBLE_LEN; txd_o=0xD5 at T+PREAMBLE_LEN+1.
REQ-016 mac_ack_o = mac_valid_i AND state==DATA (combinational); never asserted in any other state.
REQ-017 DATA is entered on the SFD output cycle; each acked byte appears on txd_o exactly one cycle after its ack.
REQ-018 Byte counter 11 bits, cleared in IDLE, incremented per DATA/PAD byte, saturates at 2047.
REQ-019 mac_valid_i=0 in DATA ends the payload: count<MIN_PAYLOAD -> PAD, otherwise -> FCS (or IFG, see REQ-027).
REQ-020 PAD emits 0x00 bytes until count==MIN_PAYLOAD, with no gap between payload and pad.
REQ-021 CRC: IEEE 802.3, reflected poly 0xEDB88320, init 0xFFFFFFFF, over all DATA and PAD bytes, LSB-first per byte.
REQ-022 FCS: four bytes of ~crc, least-significant byte first, following the last DATA/PAD byte without a gap.
REQ-023 frame_done_o pulses with the last FCS byte (last DATA/PAD byte when FCS is compiled out).
REQ-024 IFG: tx_en_o=0 for exactly IFG_CYCLES cycles, then IDLE; mac_valid_i during IFG is ignored and not acked.
REQ-025 Zero-length frame (mac_valid_i drops on the first DATA cycle): MIN_PAYLOAD pad bytes, then FCS.

Reset
REQ-026 rst=1: immediate (asynchronous) state IDLE; txd_o=0x00, tx_en_o=0, busy_o=0, frame_done_o=0, counters 0, crc=0xFFFFFFFF; a frame cut mid-transmission is abandoned and not resumed.

Configuration
REQ-027 Macro ETH_TX_FCS_EN defined: FCS state and CRC logic present, per REQ-021/022. Undefined: no CRC logic; PAD/DATA end -> IFG directly, frame carries no FCS.

Verification
REQ-028 MIN_PAYLOAD=9, ETH_TX_FCS_EN, input "123456789" (0x31..0x39) -> txd_o 7x0x55, 0xD5, 0x31..0x39, 0x26, 0x39, 0xF4, 0xCB; frame_done_o on 0xCB; then 12 cycles tx_en_o=0.
REQ-029 Defaults, 42-byte ARP-reply stream -> 42 data bytes, 18 bytes 0x00, 4 FCS bytes matching the bench CRC model; 72 tx_en_o cycles in total.
REQ-030 Defaults, 98-byte ICMP frame -> no pad; 8+98+4 tx_en_o cycles; exactly 98 mac_ack_o pulses, each one cycle before its byte on txd_o.
REQ-031 Second frame presented with mac_valid_i=1 during IFG -> mac_ack_o stays 0; preamble starts the cycle after IFG expires; both frames intact.
REQ-032 rst asserted at byte 20 of DATA -> same-cycle tx_en_o=0, busy_o=0; after release a new frame is transmitted correctly from its preamble.
REQ-033 ETH_TX_FCS_EN undefined, zero-length frame -> 8 preamble/SFD bytes, 60 bytes 0x00, no FCS, frame_done_o on the 60th zero byte.

Source files
------------

// File: rtl/eth_tx_framer.sv
// GMII-style transmit framer: preamble/SFD, payload, zero pad to MIN_PAYLOAD, optional FCS, then IFG.
// Define ETH_TX_FCS_EN to append the IEEE 802.3 CRC-32 FCS; without it frames end after payload/pad.
module eth_tx_framer #(
    parameter int MIN_PAYLOAD  = 60,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mac_data_i,
    input  logic       mac_valid_i,
    output logic       mac_ack_o,
    output logic [7:0] txd_o,
    output logic       tx_en_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
    } state_t;

    // State names the byte being decided for the next cycle; SFD shows the last 0x55, DATA shows 0xD5 first.
    localparam logic [7:0]  PRE_LOAD = 8'((PREAMBLE_LEN >= 2) ? (PREAMBLE_LEN - 2) : 0);
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_PAYLOAD);
`ifdef ETH_TX_FCS_EN
    localparam state_t END_STATE = S_FCS;
`else
    localparam state_t END_STATE = S_IFG;
`endif

    state_t      state_q, state_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic [7:0]  timer_q, timer_d;
    logic [10:0] count_q, count_d;
    logic        pay_load;
    logic        pay_end;
    logic [7:0]  pay_byte;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_q, crc_d, fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ ((c[0] ^ data[i]) ? 32'hEDB88320 : 32'h0000_0000);
        end
        return c;
    endfunction

    always_comb begin
        fcs_word = ~crc_q;
        crc_d    = crc_q;
        if (state_q == S_IDLE) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (pay_load) begin
            crc_d = crc_byte(crc_q, pay_byte);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            txd_q   <= 8'h00;
            tx_en_q <= 1'b0;
            timer_q <= 8'h00;
            count_q <= 11'd0;
`ifdef ETH_TX_FCS_EN
            crc_q   <= 32'hFFFF_FFFF;
`endif
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            timer_q <= timer_d;
            count_q <= count_d;
`ifdef ETH_TX_FCS_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (mac_valid_i) state_d = (PREAMBLE_LEN >= 2) ? S_PREAMBLE : S_SFD;
            S_PREAMBLE: if (timer_q == 8'd0) state_d = S_SFD;
            S_SFD:      state_d = S_DATA;
            S_DATA:     if (!mac_valid_i) state_d = (count_q < MIN_CNT) ? S_PAD : END_STATE;
            S_PAD:      if (count_q >= MIN_CNT) state_d = END_STATE;
            S_FCS:      if (timer_q == 8'd0) state_d = S_IFG;
            S_IFG:      if (timer_q == 8'd0) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        txd_d    = 8'h00;
        tx_en_d  = 1'b0;
        timer_d  = timer_q;
        count_d  = count_q;
        pay_load = 1'b0;
        pay_end  = 1'b0;
        pay_byte = 8'h00;
        case (state_q)
            S_IDLE: begin
                count_d = 11'd0;
                timer_d = PRE_LOAD;
                if (mac_valid_i) begin
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
            end
            S_PREAMBLE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
            end
            S_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
            end
            S_DATA: begin
                if (mac_valid_i) begin
                    pay_load = 1'b1;
                    pay_byte = mac_data_i;
                end else if (count_q < MIN_CNT) begin
                    pay_load = 1'b1;
                end else begin
                    pay_end = 1'b1;
                end
            end
            S_PAD: begin
                if (count_q < MIN_CNT) pay_load = 1'b1;
                else pay_end = 1'b1;
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                if (timer_q != 8'd0) begin
                    tx_en_d = 1'b1;
                    timer_d = timer_q - 8'd1;
                    case (timer_q[1:0])
                        2'd3:    txd_d = fcs_word[15:8];
                        2'd2:    txd_d = fcs_word[23:16];
                        default: txd_d = fcs_word[31:24];
                    endcase
                end else begin
                    timer_d = IFG_LOAD;
                end
            end
`endif
            S_IFG: begin
                if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
            end
            default: ;
        endcase

        if (pay_load) begin
            txd_d   = pay_byte;
            tx_en_d = 1'b1;
            if (count_q != 11'h7FF) count_d = count_q + 11'd1;
        end
        // First FCS byte leaves right behind the last payload/pad byte; timer then indexes bytes 1..3.
        if (pay_end) begin
`ifdef ETH_TX_FCS_EN
            txd_d   = fcs_word[7:0];
            tx_en_d = 1'b1;
            timer_d = 8'd3;
`else
            timer_d = IFG_LOAD;
`endif
        end
    end

    always_comb begin
        mac_ack_o = mac_valid_i && (state_q == S_DATA);
        busy_o    = (state_q != S_IDLE);
`ifdef ETH_TX_FCS_EN
        frame_done_o = (state_q == S_FCS) && (timer_q == 8'd0);
`else
        frame_done_o = ((state_q == S_DATA) && !mac_valid_i && (count_q >= MIN_CNT)) ||
                       ((state_q == S_PAD) && (count_q >= MIN_CNT));
`endif
    end

    assign txd_o   = txd_q;
    assign tx_en_o = tx_en_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: a MIN_PAYLOAD=9 instance and a default instance share stimulus.
// Expectations follow the ETH_TX_FCS_EN setting of the build.
module tb_eth_tx_framer;
    localparam int PRE = 7;
    localparam int IFG = 12;
`ifdef ETH_TX_FCS_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    typedef struct {
        bit sel;
        int len;
        int seed;
        int exp_pad;
        int exp_en;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mac_data = 8'h00;
    logic       mac_valid = 1'b0;
    logic       sel = 1'b0;
    logic       valid_a, valid_b;
    logic       ack_a, en_a, busy_a, done_a;
    logic       ack_b, en_b, busy_b, done_b;
    logic [7:0] txd_a, txd_b;
    logic       s_ack, s_en, s_busy, s_done;
    logic [7:0] s_txd;

    assign valid_a = mac_valid & ~sel;
    assign valid_b = mac_valid & sel;
    assign s_ack   = sel ? ack_b  : ack_a;
    assign s_en    = sel ? en_b   : en_a;
    assign s_busy  = sel ? busy_b : busy_a;
    assign s_done  = sel ? done_b : done_a;
    assign s_txd   = sel ? txd_b  : txd_a;

    eth_tx_framer #(.MIN_PAYLOAD(9)) dut_a (
        .clk(clk), .rst(rst), .mac_data_i(mac_data), .mac_valid_i(valid_a),
        .mac_ack_o(ack_a), .txd_o(txd_a), .tx_en_o(en_a), .busy_o(busy_a), .frame_done_o(done_a)
    );

    eth_tx_framer dut_b (
        .clk(clk), .rst(rst), .mac_data_i(mac_data), .mac_valid_i(valid_b),
        .mac_ack_o(ack_b), .txd_o(txd_b), .tx_en_o(en_b), .busy_o(busy_b), .frame_done_o(done_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] pl [0:511];
    int nfr;
    int flen [0:1];
    int fpad [0:1];
    int foff [0:1];
    logic [7:0] q_txd [$];
    bit q_en [$];
    bit q_done [$];
    bit q_ack [$];
    bit q_busy [$];
    logic [7:0] got_q [$];
    vec_t vecs [0:7];
    logic [7:0] gold [0:20] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                                8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                8'h26, 8'h39, 8'hF4, 8'hCB};

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] r;
        logic fb;
        r = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    // Drives nfr frames from pl[] and logs the selected DUT each cycle; frame k+1 is offered
    // from the cycle after frame k's frame_done, i.e. while the DUT sits in IFG.
    task automatic run_frames(input int budget);
        int fr = 0, idx = 0, cyc_in = 0, ndone = 0, cyc = 0;
        bit pend = 0, active = 1, fin = 0;
        q_txd.delete(); q_en.delete(); q_done.delete(); q_ack.delete(); q_busy.delete();
        @(posedge clk); #1;
        while (!fin) begin
            if (pend) idx++;
            if (active) begin
                mac_valid = (idx < flen[fr]) || (flen[fr] == 0 && cyc_in < PRE + 1);
                mac_data  = (idx < flen[fr]) ? pl[foff[fr] + idx] : 8'h00;
            end else begin
                mac_valid = 1'b0;
                mac_data  = 8'h00;
            end
            #1;
            q_txd.push_back(s_txd);
            q_en.push_back(s_en);
            q_done.push_back(s_done);
            q_ack.push_back(s_ack);
            q_busy.push_back(s_busy);
            pend = s_ack;
            if (s_done) begin
                ndone++;
                if (ndone < nfr) begin
                    fr++;
                    idx = 0;
                    cyc_in = -1;
                    pend = 0;
                end else begin
                    active = 0;
                end
            end
            if (ndone >= nfr && !s_busy) begin
                fin = 1;
            end else if (cyc >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout: frame did not complete within %0d cycles", budget);
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
                cyc_in++;
            end
        end
        mac_valid = 1'b0;
        mac_data  = 8'h00;
    endtask

    task automatic check_run(input string nm, input int exp_en);
        logic [7:0] eb [$];
        logic [31:0] crc;
        int mism, bad, k, total_len, c0, nb, n, sz;
        total_len = 0;
        got_q.delete();
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < PRE; i++) eb.push_back(8'h55);
            eb.push_back(8'hD5);
            crc = 32'hFFFF_FFFF;
            for (int i = 0; i < flen[f]; i++) begin
                eb.push_back(pl[foff[f] + i]);
                crc = crc_upd(crc, pl[foff[f] + i]);
            end
            for (int i = 0; i < fpad[f]; i++) begin
                eb.push_back(8'h00);
                crc = crc_upd(crc, 8'h00);
            end
`ifdef ETH_TX_FCS_EN
            for (int i = 0; i < 4; i++) eb.push_back(8'((~crc) >> (8 * i)));
`endif
            total_len += flen[f];
        end
        sz = q_en.size();
        bad = 0;
        for (int i = 0; i < sz; i++) begin
            if (q_en[i]) got_q.push_back(q_txd[i]);
            else if (q_txd[i] != 8'h00) bad++;
        end
        check({nm, " en_cycles"}, got_q.size(), exp_en);
        check({nm, " txd_idle"}, bad, 0);
        n = (got_q.size() < eb.size()) ? got_q.size() : eb.size();
        mism = (got_q.size() == eb.size()) ? 0 : 1;
        for (int i = 0; i < n; i++) if (got_q[i] != eb[i]) mism++;
        check({nm, " stream"}, mism, 0);
        nb = 0;
        for (int i = 0; i < sz; i++) if (q_en[i] && (i == 0 || !q_en[i-1])) nb++;
        check({nm, " bursts"}, nb, nfr);
        k = 0; bad = 0; c0 = -1;
        for (int i = 0; i < sz; i++) begin
            if (q_done[i]) begin
                k++;
                if (c0 < 0) c0 = i;
                if (!q_en[i]) bad++;
                for (int j = 1; j <= IFG; j++) begin
                    if (i + j >= sz) bad++;
                    else if (q_en[i+j] || !q_busy[i+j] || q_ack[i+j]) bad++;
                end
                if (i + IFG + 1 >= sz) bad++;
                else if (q_busy[i+IFG+1]) bad++;
            end
        end
        check({nm, " done_cnt"}, k, nfr);
        check({nm, " done_ifg"}, bad, 0);
        if (nfr > 1) begin
            nb = -1;
            for (int i = c0 + 1; i < sz; i++) begin
                if (q_en[i]) begin
                    nb = i - c0 - 1;
                    break;
                end
            end
            check({nm, " b2b_gap"}, nb, IFG + 1);
        end
        k = 0; bad = 0;
        for (int i = 0; i < sz; i++) begin
            if (q_ack[i]) begin
                if (i + 1 >= sz || k >= 512) bad++;
                else if (!q_en[i+1] || q_txd[i+1] != pl[k]) bad++;
                k++;
            end
        end
        check({nm, " ack_cnt"}, k, total_len);
        check({nm, " ack_align"}, bad, 0);
    endtask

    task automatic fill(input int len, input int seed);
        for (int i = 0; i < len; i++) pl[i] = 8'(seed * 29 + i * 7 + 3);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, mism;
        bit pend, hit;
        vecs[0] = '{1'b1, 42, 3, 18, 68 + FL};
        vecs[1] = '{1'b1, 98, 5, 0, 106 + FL};
        vecs[2] = '{1'b1, 0, 0, 60, 68 + FL};
        vecs[3] = '{1'b1, 60, 7, 0, 68 + FL};
        vecs[4] = '{1'b1, 59, 9, 1, 68 + FL};
        vecs[5] = '{1'b0, 9, 11, 0, 17 + FL};
        vecs[6] = '{1'b0, 3, 13, 6, 17 + FL};
        vecs[7] = '{1'b0, 20, 17, 0, 28 + FL};

        #1 rst = 1'b1;
        #1;
        check("reset tx_en_a", int'(en_a), 0);
        check("reset txd_a", int'(txd_a), 0);
        check("reset busy_a", int'(busy_a), 0);
        check("reset tx_en_b", int'(en_b), 0);
        check("reset busy_b", int'(busy_b), 0);
        check("reset done_b", int'(done_b), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            sel = vecs[v].sel;
            nfr = 1;
            flen[0] = vecs[v].len;
            fpad[0] = vecs[v].exp_pad;
            foff[0] = 0;
            fill(vecs[v].len, vecs[v].seed);
            run_frames(1000);
            check_run($sformatf("vec%0d", v), vecs[v].exp_en);
        end

        // "123456789" on the MIN_PAYLOAD=9 instance against the known CRC-32 check value.
        sel = 1'b0;
        nfr = 1; flen[0] = 9; fpad[0] = 0; foff[0] = 0;
        for (int i = 0; i < 9; i++) pl[i] = 8'(8'h31 + i);
        run_frames(1000);
        check_run("crc9", 17 + FL);
        mism = 0;
        for (int i = 0; i < 17 + FL; i++) begin
            if (i >= got_q.size()) mism++;
            else if (got_q[i] != gold[i]) mism++;
        end
        check("crc9 golden", mism, 0);

        // Second frame offered throughout the IFG of the first.
        sel = 1'b1;
        nfr = 2;
        flen[0] = 10; fpad[0] = 50; foff[0] = 0;
        flen[1] = 64; fpad[1] = 0;  foff[1] = 10;
        fill(74, 21);
        run_frames(1000);
        check_run("b2b", 140 + 2 * FL);

        // Reset while the 21st payload byte is offered.
        sel = 1'b1;
        fill(40, 23);
        idx = 0; pend = 0; hit = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 200; c++) begin
            if (pend) idx++;
            mac_valid = 1'b1;
            mac_data  = pl[idx];
            #1;
            pend = s_ack;
            if (idx == 20) begin
                hit = 1;
                break;
            end
            @(posedge clk); #1;
        end
        check("rst reach byte20", int'(hit), 1);
        check("rst pre tx_en", int'(en_b), 1);
        rst = 1'b1;
        #1;
        check("rst same-cycle tx_en", int'(en_b), 0);
        check("rst same-cycle busy", int'(busy_b), 0);
        check("rst same-cycle txd", int'(txd_b), 0);
        check("rst same-cycle ack", int'(ack_b), 0);
        mac_valid = 1'b0;
        mac_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst hold tx_en", int'(en_b), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst no resume busy", int'(busy_b), 0);
        check("rst no resume tx_en", int'(en_b), 0);
        nfr = 1; flen[0] = 30; fpad[0] = 30; foff[0] = 0;
        fill(30, 27);
        run_frames(1000);
        check_run("after_rst", 68 + FL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
